// File: rtl/mux_case.sv
// 4:1 mux with a combinational output plus an enabled, registered copy that
// reports value changes as a one-cycle pulse and a saturating toggle count.
module mux_case #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       A,
    input  logic [1:0]       SEL,
    input  logic             EN,
    output logic             O,
    output logic             O_Q,
    output logic [1:0]       SEL_Q,
    output logic             CHG,
    output logic [CNT_W-1:0] TOG_CNT
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Default arm drives 0 for an unknown select instead of propagating X.
    always_comb begin
        O = 1'b0;
        case (SEL)
            2'd0:    O = A[0];
            2'd1:    O = A[1];
            2'd2:    O = A[2];
            2'd3:    O = A[3];
            default: O = 1'b0;
        endcase
    end

    // Change detection compares the value being captured against the held
    // O_Q, so CHG and TOG_CNT update on the same edge as O_Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_Q     <= 1'b0;
            SEL_Q   <= 2'd0;
            CHG     <= 1'b0;
            TOG_CNT <= '0;
        end else begin
            CHG <= 1'b0;
            if (EN) begin
                O_Q   <= O;
                SEL_Q <= SEL;
                if (O != O_Q) begin
                    CHG <= 1'b1;
                    if (TOG_CNT != CNT_MAX)
                        TOG_CNT <= TOG_CNT + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_case.sv
// Directed bench for mux_case: combinational select, enabled capture, change
// pulse, saturating counter (CNT_W=8 and CNT_W=2) and async reset.
module tb_mux_case;

    logic       clk = 1'b0;
    logic       run_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] A = 4'd0;
    logic [1:0] SEL = 2'd0;
    logic       EN = 1'b0;

    logic       o8, oq8, chg8;
    logic [1:0] selq8;
    logic [7:0] cnt8;
    logic       o2, oq2, chg2;
    logic [1:0] selq2;
    logic [1:0] cnt2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = run_clk ? ~clk : clk;

    mux_case #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(A), .SEL(SEL), .EN(EN),
        .O(o8), .O_Q(oq8), .SEL_Q(selq8), .CHG(chg8), .TOG_CNT(cnt8)
    );

    mux_case #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .SEL(SEL), .EN(EN),
        .O(o2), .O_Q(oq2), .SEL_Q(selq2), .CHG(chg2), .TOG_CNT(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic oq, input logic [1:0] sq,
                           input logic ch, input logic [7:0] c8, input logic [1:0] c2);
        chk({tag, ".oq8"}, oq8, oq);
        chk({tag, ".selq8"}, selq8, sq);
        chk({tag, ".chg8"}, chg8, ch);
        chk({tag, ".cnt8"}, cnt8, c8);
        chk({tag, ".oq2"}, oq2, oq);
        chk({tag, ".chg2"}, chg2, ch);
        chk({tag, ".cnt2"}, cnt2, c2);
    endtask

    initial begin
        logic [3:0] a_seq [4];
        logic       exp_o [4];
        logic [7:0] exp_c8 [4];
        logic [1:0] exp_c2 [4];

        // Reset with no clock running
        #1 rst_n = 1'b0;
        #1 chk_reg("rst", 1'b0, 2'd0, 1'b0, 8'd0, 2'd0);

        // Combinational select, zero delay, during reset
        A = 4'd5;
        for (int s = 0; s < 4; s++) begin
            SEL = 2'(s);
            #1 chk($sformatf("mux5.sel%0d", s), o8, (s % 2 == 0) ? 1 : 0);
        end
        SEL = 2'd3;
        #1 chk("a5_sel3", o8, 0);
        A = 4'd15;
        #1 chk("a15_sel3", o8, 1);
        A = 4'b0110; SEL = 2'd2;
        #1 chk("same_cycle_a_sel", o2, 1);

        // Release, first capture counts as a change from 0
        run_clk = 1'b1;
        edge1();
        chk_reg("held_rst", 1'b0, 2'd0, 1'b0, 8'd0, 2'd0);
        rst_n = 1'b1;
        EN = 1'b1; A = 4'd15; SEL = 2'd2;
        edge1();
        chk_reg("cap1", 1'b1, 2'd2, 1'b1, 8'd1, 2'd1);

        // Same value recaptured: no change pulse
        edge1();
        chk_reg("same", 1'b1, 2'd2, 1'b0, 8'd1, 2'd1);

        // EN=0: O follows A, registered state holds
        EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            A = (i % 2 == 0) ? 4'd0 : 4'd15;
            #1 chk($sformatf("en0.o%0d", i), o8, (i % 2 == 0) ? 0 : 1);
            edge1();
            chk_reg($sformatf("en0.%0d", i), 1'b1, 2'd2, 1'b0, 8'd1, 2'd1);
        end

        // Toggle O_Q 4 more times; CNT_W=2 saturates at 3
        a_seq  = '{4'd0, 4'd1, 4'd0, 4'd1};
        exp_o  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_c8 = '{8'd2, 8'd3, 8'd4, 8'd5};
        exp_c2 = '{2'd2, 2'd3, 2'd3, 2'd3};
        EN = 1'b1; SEL = 2'd0;
        for (int i = 0; i < 4; i++) begin
            A = a_seq[i];
            edge1();
            chk_reg($sformatf("tog%0d", i), exp_o[i], 2'd0, 1'b1, exp_c8[i], exp_c2[i]);
        end

        // Async reset pulse between edges; O keeps following A
        A = 4'b1000; SEL = 2'd3;
        rst_n = 1'b0;
        #1 chk_reg("midrst", 1'b0, 2'd0, 1'b0, 8'd0, 2'd0);
        chk("midrst.o", o8, 1);
        rst_n = 1'b1;
        EN = 1'b0;
        edge1();
        chk_reg("midrst_hold", 1'b0, 2'd0, 1'b0, 8'd0, 2'd0);

        // First capture after reset, then a 1->0 capture
        EN = 1'b1; A = 4'd1; SEL = 2'd0;
        edge1();
        chk_reg("post1", 1'b1, 2'd0, 1'b1, 8'd1, 2'd1);
        SEL = 2'd1;
        edge1();
        chk_reg("post2", 1'b0, 2'd1, 1'b1, 8'd2, 2'd2);
        EN = 1'b0;
        edge1();
        chk_reg("post3", 1'b0, 2'd1, 1'b0, 8'd2, 2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_case.md
MUX_CASE -- requirements
Module: mux_case

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the toggle counter.
REQ-002 clk  input  1  SHALL be the single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 A  input  4  SHALL carry data inputs; A[i] is input i.
REQ-005 SEL  input  2  SHALL be the unsigned select index, 0..3.
REQ-006 EN  input  1  SHALL be the capture enable for the registered path.
REQ-007 O  output  1  SHALL be the combinational mux output.
REQ-008 O_Q  output  1  SHALL be the registered mux output.
REQ-009 SEL_Q  output  2  SHALL be the select index captured with O_Q.
REQ-010 CHG  output  1  SHALL be a one-cycle pulse when O_Q changes value.
REQ-011 TOG_CNT  output  CNT_W  SHALL count O_Q changes and saturate.

Function
REQ-012 O SHALL equal A[SEL] for every SEL value 0..3, implemented as a full case statement with no latch.
REQ-013 O SHALL be purely combinational and independent of clk, rst_n and EN.
- Zero-cycle latency.
- Correct when clk, rst_n and EN are unconnected.
REQ-014 On a rising clk edge with EN=1, O_Q SHALL load A[SEL] and SEL_Q SHALL load SEL.
REQ-015 With EN=0, O_Q and SEL_Q SHALL hold their values.
REQ-016 O_Q SHALL have one-cycle latency relative to O.
REQ-017 CHG SHALL be 1 for exactly the cycle after an edge where O_Q changes value, and 0 otherwise.
REQ-018 CHG SHALL be 0 when EN=1 but the captured value equals the held O_Q.
REQ-019 TOG_CNT SHALL increment by 1 on each edge where CHG is asserted.
REQ-020 TOG_CNT SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 If SEL contains X or Z, O SHALL be driven to 0.
REQ-022 If A and SEL change in the same cycle, O SHALL reflect the new A indexed by the new SEL.

Reset
REQ-023 While rst_n=0, these outputs SHALL be forced immediately, independent of clk:
- O_Q=0
- SEL_Q=0
- CHG=0
- TOG_CNT=0
REQ-024 Reset SHALL not affect O, which continues to follow A[SEL].
REQ-025 Reset asserted mid-operation SHALL clear all registered state.
- The first edge with rst_n=1 and EN=1 captures normally.
- A capture of 1 on that edge counts as a change from 0.
REQ-026 Release of rst_n SHALL be treated as synchronous to clk by the integrator; the block contains no synchronizer.

Verification
REQ-027 A=5, SEL=0 -> O=1. Then SEL=1 -> O=0, SEL=2 -> O=1, SEL=3 -> O=0, each with zero delay.
REQ-028 A=5, SEL=3, then A=15 -> O changes 0->1 with no clock present.
REQ-029 rst_n=0 -> O_Q=0, SEL_Q=0, CHG=0, TOG_CNT=0. Release, then EN=1, A=15, SEL=2, one edge -> O_Q=1, SEL_Q=2, CHG=1 next cycle, TOG_CNT=1.
REQ-030 EN=0 with A toggled across 4 edges -> O follows A, but O_Q, SEL_Q and TOG_CNT are unchanged and CHG stays 0.
REQ-031 CNT_W=2 with O_Q toggled 5 times -> TOG_CNT reads 1, 2, 3, 3, 3.
REQ-032 rst_n pulsed low between clock edges with O_Q=1, TOG_CNT=2 -> both cleared before the next edge, and O unaffected.
